// File: rtl/amo_sequencer_pkg.sv
// Shared definitions for the RV32A read-modify-write sequencer.
//   - AMO funct5 codes (instr[31:27]) as decoded by the control path.
//   - ALU control width and operation codes the sequencer drives.
//   - amo_is_rmw():   funct5 is one of the nine read-modify-write AMOs.
//   - amo_alu_ctrl(): maps an AMO funct5 to the ALU operation that
//                     produces the word to be written back.
package amo_sequencer_pkg;

  localparam int ALU_CTRL_WIDTH = 5;
  typedef logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_t;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  localparam alu_ctrl_t ALU_ADD_ADDI = 5'd0;
  localparam alu_ctrl_t ALU_LUI      = 5'd1;  // result = operand b
  localparam alu_ctrl_t ALU_XOR_XORI = 5'd2;
  localparam alu_ctrl_t ALU_OR_ORI   = 5'd3;
  localparam alu_ctrl_t ALU_AND_ANDI = 5'd4;
  localparam alu_ctrl_t ALU_MIN      = 5'd5;
  localparam alu_ctrl_t ALU_MAX      = 5'd6;
  localparam alu_ctrl_t ALU_MINU     = 5'd7;
  localparam alu_ctrl_t ALU_MAXU     = 5'd8;

  function automatic logic amo_is_rmw(input logic [4:0] f5);
    logic r;
    case (f5)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic alu_ctrl_t amo_alu_ctrl(input logic [4:0] f5);
    alu_ctrl_t c;
    case (f5)
      AMO_SWAP: c = ALU_LUI;
      AMO_XOR:  c = ALU_XOR_XORI;
      AMO_OR:   c = ALU_OR_ORI;
      AMO_AND:  c = ALU_AND_ANDI;
      AMO_MIN:  c = ALU_MIN;
      AMO_MAX:  c = ALU_MAX;
      AMO_MINU: c = ALU_MINU;
      AMO_MAXU: c = ALU_MAXU;
      default:  c = ALU_ADD_ADDI;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/amo_sequencer_reservation.sv
// amo_reservation: LR/SC reservation register (valid bit + word address).
//   clk, reset  : clock, synchronous active-high reset (clears reservation)
//   set         : record set_word as the reserved word
//   clear       : drop the reservation (set has priority)
//   set_word    : word address (addr[31:2]) to reserve
//   match_word  : word address to compare against the reservation
//   match       : reservation valid and match_word equals the reserved word
module amo_reservation (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        clear,
  input  logic [29:0] set_word,
  input  logic [29:0] match_word,
  output logic        match
);

  logic        valid_q;
  logic [29:0] word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (set) begin
      valid_q <= 1'b1;
      word_q  <= set_word;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign match = valid_q && (word_q == match_word);

endmodule

// File: rtl/amo_sequencer.sv
// amo_sequencer: multicycle read-modify-write engine for RV32A AMOs.
// Reads the addressed word, runs it through the external ALU with rs2,
// writes the result back and returns the old word for rd.
//
// Optional feature macro: KIANV_AMO_LRSC_EN adds LR.W / SC.W and an
// amo_reservation instance; without it those funct5 codes are illegal.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               request pulse, only looked at in IDLE
//   funct5, addr, rs2   decoded AMO, effective address, source operand
//   busy                high in every state except IDLE
//   done, error         one-cycle completion pulse; error qualified by done
//   rd_value            old memory word (SC: 0 success, 1 failure)
//   mem_*               single-port memory request/response
//   alu_a, alu_b        latched loaded word / latched rs2
//   alu_control         ALU operation, ALU_ADD_ADDI except in CALC
//   alu_result          ALU output, captured in CALC
//   state_dbg           current FSM state encoding
//
// Memory handshake: mem_valid rises in READ/WRITE and stays high, with
// mem_addr/mem_wstrb/mem_wdata unchanged, until the cycle mem_ready is
// sampled high; that cycle completes the transfer (mem_rdata valid on
// reads) and mem_ready may be high in the first mem_valid cycle.
module amo_sequencer
  import amo_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [4:0]                funct5,
  input  logic [31:0]               addr,
  input  logic [31:0]               rs2,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [31:0]               rd_value,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [31:0]               mem_addr,
  output logic [3:0]                mem_wstrb,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic [31:0]               alu_a,
  output logic [31:0]               alu_b,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control,
  input  logic [31:0]               alu_result,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  funct5_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic start_lr, start_sc, lr_q, sc_hit, start_err, accept;

  assign accept = (state_q == S_IDLE) && start;

`ifdef KIANV_AMO_LRSC_EN
  logic res_set, res_clear;

  assign start_lr = (funct5 == AMO_LR);
  assign start_sc = (funct5 == AMO_SC);
  assign lr_q     = (funct5_q == AMO_LR);

  // Reserve after the LR read lands; drop on any SC request and on any
  // completed write to the reserved word.
  assign res_set   = (state_q == S_READ) && mem_ready && lr_q;
  assign res_clear = (accept && start_sc) ||
                     ((state_q == S_WRITE) && mem_ready && sc_hit);

  // In IDLE the match is for the incoming SC address; otherwise it tracks
  // the word currently being written.
  amo_reservation u_reservation (
    .clk        (clk),
    .reset      (reset),
    .set        (res_set),
    .clear      (res_clear),
    .set_word   (word_q),
    .match_word ((state_q == S_IDLE) ? addr[31:2] : word_q),
    .match      (sc_hit)
  );
`else
  assign start_lr = 1'b0;
  assign start_sc = 1'b0;
  assign lr_q     = 1'b0;
  assign sc_hit   = 1'b0;
`endif

  assign start_err = (addr[1:0] != 2'b00) ||
                     !(amo_is_rmw(funct5) || start_lr || start_sc);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_err)     state_d = S_DONE;
          else if (start_sc) state_d = sc_hit ? S_WRITE : S_DONE;
          else               state_d = S_READ;
        end
      end
      S_READ:  if (mem_ready) state_d = lr_q ? S_DONE : S_CALC;
      S_CALC:  state_d = S_WRITE;
      S_WRITE: if (mem_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      funct5_q <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rd_value <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            funct5_q <= funct5;
            word_q   <= addr[31:2];
            alu_b    <= rs2;
            err_q    <= start_err;
            // SC resolves immediately: store rs2 if it will write.
            if (!start_err && start_sc) begin
              rd_value <= sc_hit ? 32'd0 : 32'd1;
              wdata_q  <= rs2;
            end
          end
        end
        S_READ: begin
          if (mem_ready) begin
            rd_value <= mem_rdata;
            alu_a    <= mem_rdata;
          end
        end
        S_CALC:  wdata_q <= alu_result;
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = done && err_q;
  assign mem_valid   = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_addr    = {word_q, 2'b00};
  assign mem_wstrb   = (state_q == S_WRITE) ? 4'b1111 : 4'b0000;
  assign mem_wdata   = wdata_q;
  assign alu_control = (state_q == S_CALC) ? amo_alu_ctrl(funct5_q) : ALU_ADD_ADDI;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_amo_sequencer.sv
module tb_amo_sequencer;
  import amo_sequencer_pkg::*;

`ifdef KIANV_AMO_LRSC_EN
  localparam bit LRSC_EN = 1'b1;
`else
  localparam bit LRSC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  funct5 = '0;
  logic [31:0] addr = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done, error;
  logic [31:0] rd_value;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] alu_a, alu_b;
  logic [ALU_CTRL_WIDTH-1:0] alu_control;
  logic [31:0] alu_result;
  logic [2:0]  state_dbg;

  amo_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .funct5(funct5), .addr(addr),
    .rs2(rs2), .busy(busy), .done(done), .error(error), .rd_value(rd_value),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .state_dbg(state_dbg)
  );

  // ---------------- ALU environment ----------------
  always_comb begin
    case (alu_control)
      ALU_ADD_ADDI: alu_result = alu_a + alu_b;
      ALU_LUI:      alu_result = alu_b;
      ALU_XOR_XORI: alu_result = alu_a ^ alu_b;
      ALU_OR_ORI:   alu_result = alu_a | alu_b;
      ALU_AND_ANDI: alu_result = alu_a & alu_b;
      ALU_MIN:      alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      ALU_MAX:      alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      ALU_MINU:     alu_result = (alu_a < alu_b) ? alu_a : alu_b;
      ALU_MAXU:     alu_result = (alu_a > alu_b) ? alu_a : alu_b;
      default:      alu_result = 32'hDEAD_BEEF;
    endcase
  end

  // ---------------- memory responder ----------------
  int          mem_delay = 0;
  logic [31:0] init_mem [bit [29:0]];
  logic [31:0] wr_mem   [bit [29:0]];
  logic [63:0] obs_q[$];
  int          valid_cycles = 0;
  int          proto_viol = 0;
  int          rcnt = 0;
  logic [31:0] snap_addr = '0, snap_wdata = '0;
  logic [3:0]  snap_wstrb = '0;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (wr_mem.exists(w))   return wr_mem[w];
    if (init_mem.exists(w)) return init_mem[w];
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (mem_ready && !reset) begin
      rcnt = 0;
      if (snap_wstrb != 4'h0) begin
        obs_q.push_back({snap_addr, snap_wdata});
        wr_mem[snap_addr[31:2]] = snap_wdata;
      end
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (reset || !mem_valid) begin
      rcnt = 0;
    end else begin
      valid_cycles++;
      if (rcnt == 0) begin
        snap_addr  = mem_addr;
        snap_wstrb = mem_wstrb;
        snap_wdata = mem_wdata;
        if (mem_wstrb != 4'h0 && mem_wstrb != 4'hF) proto_viol++;
      end else if ({mem_addr, mem_wstrb, mem_wdata} !== {snap_addr, snap_wstrb, snap_wdata}) begin
        proto_viol++;
      end
      if (rcnt >= mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr[31:2]);
      end
      rcnt++;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] exp_q[$];
  logic [31:0] ref_mem [bit [29:0]];
  bit          res_valid = 1'b0;
  logic [29:0] res_word = '0;
  logic [31:0] exp_rd = '0, exp_alu_a = '0, exp_alu_b = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    init_mem[a[31:2]] = v;
    ref_mem[a[31:2]]  = v;
  endtask

  // Issue one AMO with the given per-phase memory delay and check all results.
  task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] b,
                        input int d, input bit hold, input string tag);
    bit is_lr, is_sc, legal, err, wr;
    int exp_lat, exp_vc, lat, vc0, pv0;
    logic [29:0] w;
    logic [31:0] old, nv;
    w = a[31:2];
    is_lr = LRSC_EN && (f5 == AMO_LR);
    is_sc = LRSC_EN && (f5 == AMO_SC);
    legal = is_lr || is_sc || (f5 inside {AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
                                          AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU});
    err = !legal || (a[1:0] != 2'b00);
    old = ref_word(w);
    wr = 1'b0;
    nv = '0;
    exp_alu_b = b;
    if (err) begin
      exp_lat = 1; exp_vc = 0;
    end else if (is_lr) begin
      exp_rd = old; exp_alu_a = old; res_valid = 1'b1; res_word = w;
      exp_lat = 2 + d; exp_vc = d + 1;
    end else if (is_sc) begin
      if (res_valid && res_word == w) begin
        wr = 1'b1; nv = b; exp_rd = 32'd0; exp_lat = 2 + d; exp_vc = d + 1;
      end else begin
        exp_rd = 32'd1; exp_lat = 1; exp_vc = 0;
      end
    end else begin
      case (f5)
        AMO_ADD:  nv = old + b;
        AMO_SWAP: nv = b;
        AMO_XOR:  nv = old ^ b;
        AMO_OR:   nv = old | b;
        AMO_AND:  nv = old & b;
        AMO_MIN:  nv = ($signed(old) < $signed(b)) ? old : b;
        AMO_MAX:  nv = ($signed(old) > $signed(b)) ? old : b;
        AMO_MINU: nv = (old < b) ? old : b;
        default:  nv = (old > b) ? old : b;
      endcase
      wr = 1'b1; exp_rd = old; exp_alu_a = old;
      if (res_valid && res_word == w) res_valid = 1'b0;
      exp_lat = 4 + 2 * d; exp_vc = 2 * (d + 1);
    end
    if (is_sc) res_valid = 1'b0;
    if (wr) begin
      ref_mem[w] = nv;
      exp_q.push_back({w, 2'b00, nv});
    end

    vc0 = valid_cycles;
    pv0 = proto_viol;
    mem_delay = d;
    funct5 = f5; addr = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    lat = 1;
    if (hold) begin
      funct5 = AMO_XOR; addr = a ^ 32'h40; rs2 = ~b;
    end else begin
      start = 1'b0;
    end
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " done_latency"}, lat, exp_lat);
    check({tag, " error"}, error, err);
    check({tag, " rd_value"}, rd_value, exp_rd);
    check({tag, " busy_at_done"}, busy, 1'b1);
    check({tag, " alu_a"}, alu_a, exp_alu_a);
    check({tag, " alu_b"}, alu_b, exp_alu_b);
    @(negedge clk);
    check({tag, " idle_busy"}, {busy, done, error}, 3'b000);
    check({tag, " mem_valid_cycles"}, valid_cycles - vc0, exp_vc);
    check({tag, " mem_stable"}, proto_viol - pv0, 0);
    check({tag, " write_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, " write_addr_data"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  logic [4:0] codes [13] = '{AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
                             AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU, 5'b00101, 5'b11111};

  // ---------------- directed + random stimulus ----------------
  initial begin
    int lat;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy/done/error", {busy, done, error}, 3'b000);
    check("reset mem_valid", mem_valid, 1'b0);
    check("reset mem_wstrb", mem_wstrb, 4'h0);
    check("reset rd_value", rd_value, 32'h0);
    check("reset alu_control", alu_control, ALU_ADD_ADDI);
    @(negedge clk);

    preload(32'h100, 32'd5);
    run_op(AMO_ADD, 32'h100, 32'd3, 0, 1'b0, "amoadd");
    preload(32'h104, 32'hFFFF_FFFF);
    run_op(AMO_MIN, 32'h104, 32'd1, 0, 1'b0, "amomin");
    preload(32'h108, 32'hFFFF_FFFF);
    run_op(AMO_MINU, 32'h108, 32'd1, 0, 1'b0, "amominu");
    preload(32'h10C, 32'h1234_5678);
    run_op(AMO_SWAP, 32'h10C, 32'hCAFE_F00D, 3, 1'b0, "amoswap_wait3");
    run_op(AMO_ADD, 32'h102, 32'd7, 0, 1'b0, "misaligned");
    run_op(5'b00101, 32'h100, 32'd7, 0, 1'b0, "illegal_funct5");
    preload(32'h110, 32'h8000_0000);
    run_op(AMO_MAX, 32'h110, 32'd9, 2, 1'b1, "amomax_start_held");

    preload(32'h200, 32'h0000_ABCD);
    run_op(AMO_LR, 32'h200, 32'd0, 0, 1'b0, "lr_200");
    run_op(AMO_SC, 32'h200, 32'h55, 1, 1'b0, "sc_200");
    run_op(AMO_SC, 32'h200, 32'h66, 0, 1'b0, "sc_200_again");
    preload(32'h300, 32'd10);
    run_op(AMO_LR, 32'h300, 32'd0, 0, 1'b0, "lr_300");
    run_op(AMO_ADD, 32'h300, 32'd1, 0, 1'b0, "amoadd_300");
    run_op(AMO_SC, 32'h300, 32'h77, 0, 1'b0, "sc_300_after_write");
    preload(32'h340, 32'd4);
    preload(32'h344, 32'd8);
    run_op(AMO_LR, 32'h340, 32'd0, 1, 1'b0, "lr_340");
    run_op(AMO_SC, 32'h344, 32'h88, 0, 1'b0, "sc_344_other_word");

    // Reset while waiting in WRITE aborts the write.
    preload(32'h500, 32'h11);
    mem_delay = 6;
    funct5 = AMO_ADD; addr = 32'h500; rs2 = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (mem_wstrb != 4'hF && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("reach_write", mem_wstrb, 4'hF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort mem_valid", mem_valid, 1'b0);
    check("abort busy/done", {busy, done}, 2'b00);
    check("abort rd_value", rd_value, 32'h0);
    check("abort alu_a", alu_a, 32'h0);
    check("abort no_write", obs_q.size(), 0);
    obs_q.delete();
    res_valid = 1'b0; exp_rd = '0; exp_alu_a = '0; exp_alu_b = '0;
    @(negedge clk);
    run_op(AMO_OR, 32'h500, 32'hF0, 0, 1'b0, "amoor_after_abort");

    for (int i = 0; i < 32; i++) preload(32'h400 + 32'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      a = 32'h400 + 32'(4 * $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      run_op(codes[$urandom_range(0, 12)], a, $urandom, $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
